instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
Parametrised instruction memory for the CPU fetch stage, succeeding the combinational file-initialised instruction ROM. Adds a run-time program-load port with valid/ready handshake, a post-reset clear sweep, a registered fetch read with valid and stall, byte- or word-addressed PC, and out-of-range detection that substitutes a NOP. It sits between the PC register and the decoder; a loader or testbench programs it before the core runs.

Parameters:
WIDTH, 32, instruction and PC width in bits
DEPTH, 64, number of instruction words
ADDR_W, 6, index width; must satisfy 2**ADDR_W >= DEPTH
BYTE_ADDR, 1, 1: fetch_addr is a byte address and index = fetch_addr >> 2; 0: index = fetch_addr
NOP_WORD, 32'h00000013, word returned on an out-of-range fetch

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-low
load  in  1  level; high requests and holds program-load mode
load_valid  in  1  load_data is valid this cycle
load_data  in  WIDTH  instruction word to write
load_ready  out  1  memory accepts a load word this cycle
load_done  out  1  one-cycle pulse when load mode ends
load_count  out  ADDR_W+1  words written in the last or current load session
fetch_req  in  1  fetch request
fetch_addr  in  WIDTH  PC value
fetch_valid  out  1  fetch_data and fetch_err valid
fetch_data  out  WIDTH  fetched instruction
fetch_err  out  1  fetch index was >= DEPTH
busy  out  1  block is not in IDLE; fetches stall

Behaviour:
- Reset (rst=0, asynchronous): state=CLEAR, clear pointer=0, load_count=0, load_ready=0, load_done=0, fetch_valid=0, fetch_data=0, fetch_err=0. busy=1. A reset mid-load aborts the session; the memory is re-cleared.
- CLEAR: writes 0 to mem[ptr] each cycle and increments ptr. After writing DEPTH-1 it moves to IDLE, taking exactly DEPTH cycles after reset release. load and fetch_req are ignored.
- IDLE: busy=0. load=1 moves to LOAD next cycle, with write pointer=0 and load_count=0. If load and fetch_req are high in the same cycle, load wins and the fetch is not served.
- LOAD: busy=1.
  - load_ready=1 while load=1 and wptr<DEPTH.
  - On load_valid & load_ready, mem[wptr]<=load_data, then wptr and load_count increment.
  - At wptr==DEPTH, load_ready=0 and further load_valid is ignored with no wrap.
  - load=0 moves to IDLE and pulses load_done for exactly the first IDLE cycle. A load_valid in that cycle is ignored.
  - load_count holds its value until the next session starts.
  - Words not written keep their previous contents.
- Fetch (IDLE only):
  - A fetch_req sampled at edge N gives fetch_valid=1 during the cycle after edge N, which is one cycle of latency.
  - Back-to-back requests give one result per cycle.
  - fetch_req=0 gives fetch_valid=0 the next cycle, and fetch_data/fetch_err hold their last values.
  - fetch_req while busy gives fetch_valid=0, a stall; the requester must hold the request.
- Index and range:
  - idx = BYTE_ADDR ? fetch_addr>>2 : fetch_addr, using the full width with no truncation before the range check.
  - BYTE_ADDR=1 ignores the low 2 bits.
  - If idx>=DEPTH: fetch_data=NOP_WORD and fetch_err=1. Otherwise fetch_data=mem[idx] and fetch_err=0.
- Memory is single-write. Load writes and fetch reads never coincide because they run in exclusive states.

Test Plan:
- Release reset, hold fetch_req=1 with fetch_addr=0 -> busy=1 for 64 cycles, fetch_valid=0 throughout; first fetch_valid=1 appears the cycle after busy falls, with fetch_data=0 and fetch_err=0.
- Load 3 words 0x00500093, 0x00A00113, 0x002081B3, with load_valid gaps, then drop load -> load_done pulses one cycle and load_count=3. Fetch addrs 0, 4, 8 back-to-back -> three consecutive fetch_valid cycles returning those words.
- BYTE_ADDR=1, fetch_addr=0x100 (idx 64) -> fetch_data=0x00000013, fetch_err=1. Then fetch_addr=0xFC -> mem[63], fetch_err=0.
- Offer 70 words in one session -> load_ready drops after 64 accepted, load_count=64, words 65-70 are not written, and the state stays in LOAD until load=0.
- Assert load and fetch_req in the same IDLE cycle -> fetch_valid=0 next cycle and busy=1.
- Pulse rst low after 10 load words -> all outputs reset at once, CLEAR runs, and after completion fetch_addr=0 returns 0.

Source files
------------

// File: rtl/instr_mem_ctrl_if.sv
// Handshake/bus bundle for the instruction memory: program-load port,
// fetch port and the busy/stall indication.
interface instr_mem_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
);
  logic              load;
  logic              load_valid;
  logic [WIDTH-1:0]  load_data;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              fetch_req;
  logic [WIDTH-1:0]  fetch_addr;
  logic              fetch_valid;
  logic [WIDTH-1:0]  fetch_data;
  logic              fetch_err;
  logic              busy;

  modport slave (
    input  load, load_valid, load_data, fetch_req, fetch_addr,
    output load_ready, load_done, load_count, fetch_valid, fetch_data,
           fetch_err, busy
  );

  modport master (
    output load, load_valid, load_data, fetch_req, fetch_addr,
    input  load_ready, load_done, load_count, fetch_valid, fetch_data,
           fetch_err, busy
  );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory for the fetch stage: clears itself after reset,
// accepts a program over a valid/ready load port, then serves registered
// fetches with out-of-range detection (NOP substituted, err flagged).
module instr_mem_ctrl #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 64,
  parameter int               ADDR_W    = 6,
  parameter bit               BYTE_ADDR = 1'b1,
  parameter logic [WIDTH-1:0] NOP_WORD  = WIDTH'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst,
  instr_mem_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } fetch_rsp_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);
  localparam logic [WIDTH-1:0]  DEPTH_W  = WIDTH'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;       // clear sweep pointer
  logic [ADDR_W:0]   cnt_q, cnt_d;       // load write pointer == load_count
  logic              done_q, done_d;
  logic              fv_q, fv_d;
  fetch_rsp_t        rsp_q, rsp_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  idx;
  logic              in_range;
  logic              ld_rdy;

  // Full-width index so a huge PC can never alias back into range.
  always_comb begin
    idx      = BYTE_ADDR ? (bus.fetch_addr >> 2) : bus.fetch_addr;
    in_range = (idx < DEPTH_W);
    ld_rdy   = (state_q == S_LOAD) && bus.load && (cnt_q < DEPTH_C);
  end

  // Next-state, memory write port and fetch response selection.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fv_d    = 1'b0;
    rsp_d   = rsp_q;
    we      = 1'b0;
    waddr   = ptr_q;
    wdata   = '0;
    case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_q == LAST_IDX) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      S_IDLE: begin
        if (bus.load) begin
          // load has priority; a simultaneous fetch is dropped
          state_d = S_LOAD;
          cnt_d   = '0;
        end else if (bus.fetch_req) begin
          fv_d       = 1'b1;
          rsp_d.data = in_range ? mem[idx[ADDR_W-1:0]] : NOP_WORD;
          rsp_d.err  = ~in_range;
        end
      end
      S_LOAD: begin
        if (!bus.load) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (bus.load_valid && ld_rdy) begin
          we    = 1'b1;
          waddr = cnt_q[ADDR_W-1:0];
          wdata = bus.load_data;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Control and response registers; reset aborts any load session.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fv_q    <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fv_q    <= fv_d;
      rsp_q   <= rsp_d;
    end
  end

  // Single write port shared by the clear sweep and the loader.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.load_ready  = ld_rdy;
  assign bus.load_done   = done_q;
  assign bus.load_count  = cnt_q;
  assign bus.fetch_valid = fv_q;
  assign bus.fetch_data  = rsp_q.data;
  assign bus.fetch_err   = rsp_q.err;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: fetch results checked through a scoreboard
// fed from a reference copy of the memory contents.
module tb_instr_mem_ctrl;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  logic [31:0] model [64];

  always #5 clk = ~clk;

  instr_mem_ctrl_if #(.WIDTH(32), .ADDR_W(6)) bus_if ();

  instr_mem_ctrl #(
    .WIDTH(32), .DEPTH(64), .ADDR_W(6), .BYTE_ADDR(1'b1),
    .NOP_WORD(32'h00000013)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_t        e;
    logic [31:0] i;
    i = a >> 2;
    if (i >= 32'd64) begin
      e.d = 32'h00000013;
      e.e = 1'b1;
    end else begin
      e.d = model[i[5:0]];
      e.e = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every fetch_valid must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && bus_if.fetch_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected: fetch_valid with data=%h err=%b, none required",
                 bus_if.fetch_data, bus_if.fetch_err);
      end else begin
        e = sb.pop_front();
        if (bus_if.fetch_data !== e.d || bus_if.fetch_err !== e.e) begin
          errors++;
          $display("FAIL fetch_result: got data=%h err=%b, required data=%h err=%b",
                   bus_if.fetch_data, bus_if.fetch_err, e.d, e.e);
        end
      end
    end
  end

  task automatic test_reset();
    int n;
    int fvb;
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.load_ready !== 1'b0 || bus_if.load_done !== 1'b0 ||
        bus_if.load_count !== 7'd0 || bus_if.fetch_valid !== 1'b0 ||
        bus_if.fetch_data !== 32'd0 || bus_if.fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rdy=%b done=%b cnt=%0d fv=%b data=%h err=%b, required 1 0 0 0 0 0 0",
               bus_if.busy, bus_if.load_ready, bus_if.load_done, bus_if.load_count,
               bus_if.fetch_valid, bus_if.fetch_data, bus_if.fetch_err);
    end
    rst = 1'b1;
    n = 0; fvb = 0;
    while (bus_if.busy === 1'b1 && n < 200) begin
      if (bus_if.fetch_valid !== 1'b0) fvb++;
      tick();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL clear_cycles: busy for %0d cycles, required 64", n);
    end
    checks++;
    if (fvb != 0) begin
      errors++;
      $display("FAIL stall_during_clear: fetch_valid seen %0d times, required 0", fvb);
    end
    push_fetch(32'd0);
    tick();
    checks++;
    if (bus_if.fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_fetch_valid: got %b, required 1", bus_if.fetch_valid);
    end
    bus_if.fetch_req = 1'b0;
    tick();
    checks++;
    if (bus_if.fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle_valid: got %b, required 0", bus_if.fetch_valid);
    end
  endtask

  task automatic test_load_fetch();
    logic [31:0] w [3];
    w[0] = 32'h00500093; w[1] = 32'h00A00113; w[2] = 32'h002081B3;
    bus_if.load = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = w[k];
      tick();
      model[k] = w[k];
      bus_if.load_valid = 1'b0;
      repeat (k + 1) tick();
    end
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.load_count !== 7'd3) begin
      errors++;
      $display("FAIL load_in_progress: busy=%b cnt=%0d, required busy=1 cnt=3",
               bus_if.busy, bus_if.load_count);
    end
    bus_if.load = 1'b0;
    tick();
    checks++;
    if (bus_if.load_done !== 1'b1 || bus_if.load_count !== 7'd3 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_done_pulse: done=%b cnt=%0d busy=%b, required 1 3 0",
               bus_if.load_done, bus_if.load_count, bus_if.busy);
    end
    tick();
    checks++;
    if (bus_if.load_done !== 1'b0) begin
      errors++;
      $display("FAIL load_done_width: done=%b in second IDLE cycle, required 0", bus_if.load_done);
    end
    for (int k = 0; k < 3; k++) begin
      bus_if.fetch_addr = 32'(k * 4);
      bus_if.fetch_req  = 1'b1;
      push_fetch(32'(k * 4));
      tick();
      checks++;
      if (bus_if.fetch_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back_valid: fetch %0d valid=%b, required 1", k, bus_if.fetch_valid);
      end
    end
    bus_if.fetch_req = 1'b0;
    tick();
    checks++;
    if (bus_if.fetch_valid !== 1'b0 || bus_if.fetch_data !== w[2]) begin
      errors++;
      $display("FAIL fetch_hold: valid=%b data=%h, required valid=0 data=%h",
               bus_if.fetch_valid, bus_if.fetch_data, w[2]);
    end
  endtask

  task automatic test_overflow();
    int          mc;
    logic        exp_rdy;
    logic [31:0] d;
    mc = 0;
    bus_if.load = 1'b1;
    tick();
    for (int i = 0; i < 70; i++) begin
      d = 32'hA0000000 | 32'(i);
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = d;
      exp_rdy = (mc < 64);
      #1;
      checks++;
      if (bus_if.load_ready !== exp_rdy) begin
        errors++;
        $display("FAIL load_ready_%0d: got %b, required %b", i, bus_if.load_ready, exp_rdy);
      end
      tick();
      if (exp_rdy) begin
        model[mc] = d;
        mc++;
      end
    end
    bus_if.load_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus_if.load_count !== 7'd64 || bus_if.load_ready !== 1'b0 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: cnt=%0d rdy=%b busy=%b, required 64 0 1",
               bus_if.load_count, bus_if.load_ready, bus_if.busy);
    end
    bus_if.load = 1'b0;
    tick();
    checks++;
    if (bus_if.load_done !== 1'b1 || bus_if.load_count !== 7'd64) begin
      errors++;
      $display("FAIL overflow_done: done=%b cnt=%0d, required 1 64",
               bus_if.load_done, bus_if.load_count);
    end
  endtask

  task automatic test_range();
    logic [31:0] addrs [6];
    addrs[0] = 32'h100; addrs[1] = 32'h101; addrs[2] = 32'hFFFFFFFC;
    addrs[3] = 32'hFC;  addrs[4] = 32'h7;   addrs[5] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      bus_if.fetch_addr = addrs[k];
      bus_if.fetch_req  = 1'b1;
      push_fetch(addrs[k]);
      tick();
    end
    bus_if.fetch_req = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL range_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_load_priority();
    bus_if.load       = 1'b1;
    bus_if.fetch_req  = 1'b1;
    bus_if.fetch_addr = 32'h0;
    tick();
    checks++;
    if (bus_if.fetch_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL load_priority: fv=%b busy=%b, required 0 1", bus_if.fetch_valid, bus_if.busy);
    end
    bus_if.load      = 1'b0;
    bus_if.fetch_req = 1'b0;
    tick();
    checks++;
    if (bus_if.load_done !== 1'b1 || bus_if.load_count !== 7'd0) begin
      errors++;
      $display("FAIL empty_session: done=%b cnt=%0d, required 1 0", bus_if.load_done, bus_if.load_count);
    end
  endtask

  task automatic test_reset_midload();
    int n;
    bus_if.load = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = 32'h55000000 + 32'(i);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.load_ready !== 1'b0 || bus_if.load_done !== 1'b0 ||
        bus_if.load_count !== 7'd0 || bus_if.fetch_valid !== 1'b0 ||
        bus_if.fetch_data !== 32'd0 || bus_if.fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: busy=%b rdy=%b done=%b cnt=%0d fv=%b data=%h err=%b, required 1 0 0 0 0 0 0",
               bus_if.busy, bus_if.load_ready, bus_if.load_done, bus_if.load_count,
               bus_if.fetch_valid, bus_if.fetch_data, bus_if.fetch_err);
    end
    bus_if.load       = 1'b0;
    bus_if.load_valid = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 32'd0;
    n = 0;
    while (bus_if.busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL reclear_cycles: busy for %0d cycles, required 64", n);
    end
    for (int k = 0; k < 2; k++) begin
      bus_if.fetch_addr = 32'(k * 20);
      bus_if.fetch_req  = 1'b1;
      push_fetch(32'(k * 20));
      tick();
    end
    bus_if.fetch_req = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reclear_drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    bus_if.load       = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.load_data  = '0;
    bus_if.fetch_req  = 1'b1;
    bus_if.fetch_addr = '0;
    for (int i = 0; i < 64; i++) model[i] = 32'd0;
    repeat (2) tick();
    test_reset();
    test_load_fetch();
    test_overflow();
    test_range();
    test_load_priority();
    test_reset_midload();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
